left_tail_seq: RTL and testbench
================================

// Module: left_tail_seq
// PURPOSE
//  Left-side tail-light sequencer, the mirror of the right-side controller.
//  - Drives three left lamps in the outward 000->001->011->111 turn pattern.
//  - Adds hazard flash and steady brake.
//  - Uses an internal clock-enable divider, not a derived clock.
//  - Sits beside the right-side sequencer under the top-level light controller.
// PARAMETERS
//  TICK_DIV  67108864  clock cycles per lamp step; legal range 2..2^CNT_W
//  CNT_W     26        width of the step divider counter
// PORTS
//  Clk      in   1  system clock; all logic on rising edge
//  Rst      in   1  synchronous, active-high reset
//  LeftEn   in   1  left turn request, level
//  Hazard   in   1  hazard request, level; overrides LeftEn
//  Brake    in   1  brake pedal, level
//  Left     out  3  lamps; Left[0] is nearest the centre, Left[2] is outermost
//  StepTick out  1  one-cycle pulse on every divider step (for L/R alignment)
// BEHAVIOUR
//  Clocking and reset
//  - One clock (Clk); reset is synchronous and active-high (Rst).
//  - Rst=1 at an edge forces state=IDLE, cnt=0, Left=3'b000, StepTick=0.
//  Divider
//  - Active = LeftEn|Hazard.
//  - When !Active, or on any state-class change, cnt is cleared to 0.
//  - Otherwise cnt increments each cycle.
//  - tick is asserted when cnt==TICK_DIV-1; cnt then wraps to 0.
//  - StepTick is registered tick (1-cycle latency), so it is high exactly 1 cycle per TICK_DIV.
//  FSM states: IDLE, L1, L2, L3, H_ON, H_OFF. Priority is Hazard > LeftEn > hold.
//  - Hazard=1 in IDLE/L1/L2/L3: next edge -> H_ON, cnt cleared.
//  - H_ON <-> H_OFF toggle on tick while Hazard=1.
//  - Hazard=0 in H_ON/H_OFF: next edge -> IDLE, cnt cleared (LeftEn resumes from IDLE).
//  - LeftEn=1, Hazard=0: IDLE->L1->L2->L3->IDLE, each step only on tick.
//    The pattern repeats while LeftEn stays high; period is 4*TICK_DIV.
//  - LeftEn=0 in L1/L2/L3: next edge -> IDLE (abort mid-sequence, no completion).
//  - Hazard and LeftEn asserted on the same edge: hazard wins.
//  Output
//  - Left is registered, computed from next-state and Brake at the same edge.
//  - Left mapping by state:
//    - IDLE: 111 if Brake, else 000.
//    - L1: 001. L2: 011. L3: 111. Brake is ignored while sequencing.
//    - H_ON: 111. H_OFF: 000. Brake is ignored in hazard.
//  - Brake-to-lamp latency in IDLE is 1 cycle.
//  - The first turn step appears TICK_DIV cycles after LeftEn rises from IDLE.
//  - No illegal states: any unused encoding returns to IDLE on the next edge.
// TESTING (TICK_DIV=4 for sim)
//  1. Rst held 2 cycles, then all inputs 0 for 20 cycles
//     -> Left=000 and StepTick=0 throughout.
//  2. LeftEn=1 at cycle 0
//     -> Left=000 until the edge at cycle 4, then 001@4, 011@8, 111@12, 000@16, 001@20.
//     -> StepTick pulses every 4 cycles.
//  3. LeftEn=1, drop to 0 while Left=011
//     -> Left=000 one edge later; reassert LeftEn -> 001 exactly 4 cycles later.
//  4. Brake=1 with LeftEn=0 -> Left=111 after 1 edge.
//     Then LeftEn=1 -> sequence 001/011/111/111(IDLE+Brake) repeating.
//  5. Hazard=1 while in L2 -> Left=111 next edge, then toggles 000/111 every 4 cycles.
//     Drop Hazard -> Left=000 (or 111 if Brake) next edge.
//  6. Rst=1 pulsed mid-sequence (Left=111) -> Left=000, cnt=0 at that edge.
//     With LeftEn still 1, first 001 appears 4 cycles after Rst falls.

Source files
------------

// File: rtl/left_tail_seq.sv
// Left tail-light sequencer: outward turn pattern, hazard flash and steady brake.
// Latency: lamps and StepTick are registered; Brake reaches the lamps in 1 cycle, turn steps every TICK_DIV cycles.
// Backpressure: none; all inputs are level requests sampled every cycle.
module left_tail_seq #(
  parameter int TICK_DIV = 67108864,
  parameter int CNT_W    = 26
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       LeftEn,
  input  logic       Hazard,
  input  logic       Brake,
  output logic [2:0] Left,
  output logic       StepTick
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    L1    = 3'd1,
    L2    = 3'd2,
    L3    = 3'd3,
    H_ON  = 3'd4,
    H_OFF = 3'd5
  } state_t;

  // Terminal count of the step divider; TICK_DIV-1 always fits in CNT_W bits.
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TICK_DIV - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       left_nxt;
  logic             active;
  logic             in_hazard;
  logic             class_chg;
  logic             cnt_clr;
  logic             tick;

  // The divider restarts whenever the lamps leave or enter the hazard group, so
  // the first step of any new pattern is a full TICK_DIV period away. A step
  // that coincides with a restart is swallowed, so no StepTick is emitted then.
  assign active    = LeftEn | Hazard;
  assign in_hazard = (state == H_ON) || (state == H_OFF);
  assign class_chg = Hazard != in_hazard;
  assign cnt_clr   = !active || class_chg;
  assign tick      = !cnt_clr && (cnt == CNT_TERM);

  // State register, divider and registered outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      cnt      <= '0;
      Left     <= 3'b000;
      StepTick <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= (cnt_clr || tick) ? '0 : cnt + CNT_W'(1);
      Left     <= left_nxt;
      StepTick <= tick;
    end
  end

  // Next state: hazard beats turn request, turn request beats hold; steps only on tick.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE, L1, L2, L3: begin
        if (Hazard) begin
          state_nxt = H_ON;
        end else if (!LeftEn) begin
          state_nxt = IDLE;
        end else if (tick) begin
          case (state)
            IDLE:    state_nxt = L1;
            L1:      state_nxt = L2;
            L2:      state_nxt = L3;
            default: state_nxt = IDLE;
          endcase
        end else begin
          state_nxt = state;
        end
      end
      H_ON, H_OFF: begin
        if (!Hazard) begin
          state_nxt = IDLE;
        end else if (tick) begin
          state_nxt = (state == H_ON) ? H_OFF : H_ON;
        end else begin
          state_nxt = state;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Lamp pattern from the state being entered; Brake only matters when idle.
  always_comb begin
    left_nxt = 3'b000;
    case (state_nxt)
      IDLE:    left_nxt = Brake ? 3'b111 : 3'b000;
      L1:      left_nxt = 3'b001;
      L2:      left_nxt = 3'b011;
      L3:      left_nxt = 3'b111;
      H_ON:    left_nxt = 3'b111;
      default: left_nxt = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_left_tail_seq.sv
// Bench for left_tail_seq: directed turn sequence plus randomized level inputs.
// Every cycle the lamps and StepTick are compared against a period/phase model.
// Inputs change 1 time unit after the rising edge and are sampled 1 unit after the next one.
module tb_left_tail_seq;

  localparam int TD = 4;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       LeftEn;
  logic       Hazard;
  logic       Brake;
  logic [2:0] Left;
  logic       StepTick;

  left_tail_seq #(
    .TICK_DIV(TD),
    .CNT_W   (4)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .LeftEn  (LeftEn),
    .Hazard  (Hazard),
    .Brake   (Brake),
    .Left    (Left),
    .StepTick(StepTick)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: which pattern is running, where in it we are, and how many
  // cycles have elapsed in the current step.
  bit         m_hazard = 1'b0;
  int         m_phase  = 0;
  int         m_cycles = 0;
  logic [2:0] m_left   = 3'b000;
  logic       m_tick   = 1'b0;
  logic [2:0] turn_pat [4] = '{3'b000, 3'b001, 3'b011, 3'b111};

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_edge(input bit r, input bit l, input bit h, input bit b);
    m_tick = 1'b0;
    if (r) begin
      m_hazard = 1'b0;
      m_phase  = 0;
      m_cycles = 0;
      m_left   = 3'b000;
    end else begin
      if (h != m_hazard) begin
        // switching between turn and hazard patterns restarts from the first step
        m_hazard = h;
        m_phase  = 0;
        m_cycles = 0;
      end else if (!h && !l) begin
        m_phase  = 0;
        m_cycles = 0;
      end else begin
        m_cycles++;
        if (m_cycles == TD) begin
          m_cycles = 0;
          m_tick   = 1'b1;
          m_phase  = (m_phase + 1) % (m_hazard ? 2 : 4);
        end
      end
      if (m_hazard)        m_left = (m_phase == 0) ? 3'b111 : 3'b000;
      else if (m_phase==0) m_left = b ? 3'b111 : 3'b000;
      else                 m_left = turn_pat[m_phase];
    end
  endtask

  task automatic step(input bit r, input bit l, input bit h, input bit b);
    Rst    = r;
    LeftEn = l;
    Hazard = h;
    Brake  = b;
    @(posedge Clk);
    #1;
    model_edge(r, l, h, b);
    chk("left", int'(Left), int'(m_left));
    chk("step_tick", int'(StepTick), int'(m_tick));
  endtask

  initial begin
    bit r, l, h, b;
    int exp_left;
    Rst    = 1'b1;
    LeftEn = 1'b0;
    Hazard = 1'b0;
    Brake  = 1'b0;

    // reset, then a quiet idle period
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0);

    // turn request from idle: 001@4, 011@8, 111@12, 000@16, 001@20
    for (int k = 1; k <= 24; k++) begin
      step(0, 1, 0, 0);
      if (k == 3 || (k % 4) == 0) begin
        exp_left = (k < 4) ? 0 : int'(turn_pat[(k / 4) % 4]);
        chk("turn_seq", int'(Left), exp_left);
      end
    end
    step(0, 0, 0, 0);

    // randomized level inputs with long dwell times and rare reset pulses
    l = 1'b0;
    h = 1'b0;
    b = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) l = !l;
      if ($urandom_range(79) == 0) h = !h;
      if ($urandom_range(11) == 0) b = !b;
      r = ($urandom_range(249) == 0);
      step(r, l, h, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
